// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Adds two WIDTH-bit operands bit-serially, LSB first, one bit per clock.
//   It reuses one fullAdder cell instead of a WIDTH-stage ripple chain.
//
//   Ports
//     clk, rst_n            rising-edge clock, asynchronous active-low reset
//     in_valid / in_ready   operand handshake (in_ready high in IDLE only)
//     a, b, cin             operands and carry into bit 0
//     out_valid / out_ready result handshake (out_valid high in DONE only)
//     sum                   a+b+cin modulo 2^WIDTH
//     carry_out             carry out of bit WIDTH-1
//     overflow              signed overflow (carry into MSB ^ carry out of MSB)
//     busy                  high while in ADD or DONE
//
//   Timing: operands accepted at edge E give out_valid from edge E+WIDTH.
//   A reset during an operation discards it; no partial result is shown.
// -----------------------------------------------------------------------------

// Single-bit full adder cell shared by every bit position of the serial add.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MSB_M1 = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Only WIDTH-1 partial sum bits are stored; the last bit comes straight
  // from the adder in the final ADD cycle.
  logic [WIDTH-2:0] r_sum_sh;
  logic             r_carry_q;
  logic             r_msb_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;
  logic             r_overflow;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_sum_full;

  fullAdder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry_q),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // Shift register contents with this cycle's sum bit entering at the MSB.
  assign w_sum_full = {w_fa_sum, r_sum_sh};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next_state = S_ADD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ADD: begin
        if (r_cnt == CNT_LAST) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_ADD;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand capture, bit-serial add and final result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_carry_q   <= 1'b0;
      r_msb_cin   <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh    <= a;
            r_b_sh    <= b;
            r_carry_q <= cin;
            r_cnt     <= '0;
          end
        end
        S_ADD: begin
          r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_sum_sh  <= w_sum_full[WIDTH-1:1];
          r_carry_q <= w_fa_cout;
          r_cnt     <= r_cnt + CNT_ONE;
          // The adder's carry while bit WIDTH-2 is processed is the carry
          // into the MSB, needed for signed overflow.
          if (r_cnt == CNT_MSB_M1) begin
            r_msb_cin <= w_fa_cout;
          end
          if (r_cnt == CNT_LAST) begin
            r_sum       <= w_sum_full;
            r_carry_out <= w_fa_cout;
            r_overflow  <= r_msb_cin ^ w_fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ADD) || (r_state == S_DONE);
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and sweep checks for serial_adder_ctrl at WIDTH=4 and WIDTH=8.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, cin, out_valid, out_ready, carry_out, overflow, busy;
  logic [3:0] a, b, sum;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, carry_out8, overflow8, busy8;
  logic [7:0] a8, b8, sum8;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_ctrl #(.WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .busy(busy)
  );

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry_out(carry_out8), .overflow(overflow8), .busy(busy8)
  );

  // Present operands for one edge; caller guarantees the DUT is in IDLE.
  task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 4'hA; b = 4'h5; cin = 1'b1;  // operands may change after acceptance
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_valid(output int lat, output bit to);
    lat = 0; to = 1'b0;
    while (!out_valid) begin
      if (lat >= 40) begin to = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; a = 4'h0; b = 4'h0; cin = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; out_ready8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, sum, carry_out, overflow} !== 9'b1_0_0_0000_0_0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b sum=%b co=%b ov=%b, want 1 0 0 0000 0 0",
               in_ready, out_valid, busy, sum, carry_out, overflow);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b vld=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  // Directed arithmetic vectors with hand-computed results.
  task automatic test_arith();
    logic [3:0] va [6] = '{4'b1100, 4'b1111, 4'b0111, 4'h0, 4'hF, 4'b0101};
    logic [3:0] vb [6] = '{4'b1010, 4'b0001, 4'b0001, 4'h0, 4'hF, 4'b1011};
    logic       vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] es [6] = '{4'b0110, 4'b0000, 4'b1000, 4'b0001, 4'hF, 4'b0000};
    logic       ec [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       eo [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat; bit to;
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vc[i]);
      wait_valid(lat, to);
      n_checks++;
      if (to || lat != 4) begin
        n_fail++;
        $display("FAIL arith_latency[%0d]: got %0d edges (timeout=%0b), want 4", i, lat, to);
      end
      n_checks++;
      if ({sum, carry_out, overflow} !== {es[i], ec[i], eo[i]}) begin
        n_fail++;
        $display("FAIL arith_result[%0d]: got sum=%b co=%b ov=%b, want sum=%b co=%b ov=%b",
                 i, sum, carry_out, overflow, es[i], ec[i], eo[i]);
      end
      release_out();
      n_checks++;
      if (in_ready !== 1'b1 || sum !== es[i]) begin
        n_fail++;
        $display("FAIL arith_hold[%0d]: got rdy=%b sum=%b, want 1 %b", i, in_ready, sum, es[i]);
      end
    end
  endtask

  // Result must stay put while out_ready is low, and new operands wait.
  task automatic test_backpressure();
    int lat; bit to;
    issue(4'b0101, 4'b0011, 1'b0);  // 1000, co 0, ov 1
    wait_valid(lat, to);
    a = 4'b0010; b = 4'b0001; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, sum, carry_out, overflow} !== 8'b1_0_1000_0_1) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: got vld=%b rdy=%b sum=%b co=%b ov=%b, want 1 0 1000 0 1",
                 i, out_valid, in_ready, sum, carry_out, overflow);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle: got rdy=%b busy=%b, want 1 0", in_ready, busy);
    end
    @(posedge clk); #1;  // held in_valid is accepted here
    in_valid = 1'b0;
    wait_valid(lat, to);
    n_checks++;
    if (to || lat != 4 || sum !== 4'b0011 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_new_op: got lat=%0d sum=%b co=%b, want lat=4 sum=0011 co=0", lat, sum, carry_out);
    end
    release_out();
  endtask

  // Reset during the second ADD cycle, then a fresh operation.
  task automatic test_reset_mid_op();
    int lat; bit to;
    issue(4'b1001, 4'b0100, 1'b0);
    @(posedge clk); #1;  // second ADD cycle
    n_checks++;
    if (busy !== 1'b1 || sum !== 4'b0011) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got busy=%b sum=%b, want 1 0011", busy, sum);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, sum, carry_out, overflow} !== 9'b1_0_0_0000_0_0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got rdy=%b vld=%b busy=%b sum=%b co=%b ov=%b, want 1 0 0 0000 0 0",
               in_ready, out_valid, busy, sum, carry_out, overflow);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'b0011, 4'b0101, 1'b0);
    wait_valid(lat, to);
    n_checks++;
    if (to || {sum, carry_out, overflow} !== 6'b1000_0_1) begin
      n_fail++;
      $display("FAIL rst_mid_fresh: got sum=%b co=%b ov=%b timeout=%0b, want 1000 0 1",
               sum, carry_out, overflow, to);
    end
    release_out();
  endtask

  // Streaming with in_valid and out_ready held high.
  task automatic test_back_to_back();
    logic [3:0] ta [4] = '{4'd3, 4'd9, 4'd15, 4'd6};
    logic [3:0] tb [4] = '{4'd4, 4'd9, 4'd1,  4'd5};
    logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0] exp;
    int acc_cnt = 0, res_cnt = 0, cyc = 0, last_acc = 0;
    bit acc, got, wait_idle = 1'b0;
    a = ta[0]; b = tb[0]; cin = tc[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (res_cnt < 4 && cyc < 80) begin
      acc = in_valid && in_ready;
      got = out_valid && out_ready;
      if (got) begin
        exp = {1'b0, ta[res_cnt]} + {1'b0, tb[res_cnt]} + {4'b0000, tc[res_cnt]};
        n_checks++;
        if ({carry_out, sum} !== exp) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got co=%b sum=%b, want co=%b sum=%b",
                   res_cnt, carry_out, sum, exp[4], exp[3:0]);
        end
        res_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
      // Accept edge to return to IDLE is WIDTH+1 edges with no stall.
      if (wait_idle && in_ready) begin
        n_checks++;
        if (cyc - last_acc != 5) begin
          n_fail++;
          $display("FAIL b2b_complete: got %0d edges, want 5", cyc - last_acc);
        end
        wait_idle = 1'b0;
      end
      if (acc) begin
        last_acc = cyc;
        wait_idle = 1'b1;
        acc_cnt++;
        if (acc_cnt < 4) begin
          a = ta[acc_cnt]; b = tb[acc_cnt]; cin = tc[acc_cnt];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (res_cnt != 4) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d results, want 4", res_cnt);
    end
  endtask

  // All 512 operand combinations with random result stalls.
  task automatic test_exhaustive();
    logic [4:0] exp;
    logic       exp_ov;
    int lat; bit to;
    for (int v = 0; v < 512; v++) begin
      issue(v[3:0], v[7:4], v[8]);
      wait_valid(lat, to);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      exp    = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0000, v[8]};
      exp_ov = (v[3] == v[7]) && (exp[3] != v[3]);
      n_checks++;
      if (to || {carry_out, sum, overflow} !== {exp, exp_ov}) begin
        n_fail++;
        $display("FAIL exh[%0d]: got co=%b sum=%b ov=%b, want co=%b sum=%b ov=%b",
                 v, carry_out, sum, overflow, exp[4], exp[3:0], exp_ov);
      end
      release_out();
    end
  endtask

  // WIDTH=8 instance with random vectors.
  task automatic test_width8();
    logic [8:0] exp;
    logic       exp_ov;
    logic [7:0] ra, rb;
    logic       rc;
    int lat;
    for (int v = 0; v < 1000; v++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      a8 = ra; b8 = rb; cin8 = rc; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0; a8 = ~ra;
      lat = 0;
      while (!out_valid8 && lat < 40) begin @(posedge clk); #1; lat++; end
      exp    = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      exp_ov = (ra[7] == rb[7]) && (exp[7] != ra[7]);
      n_checks++;
      if (lat != 8 || {carry_out8, sum8, overflow8} !== {exp, exp_ov}) begin
        n_fail++;
        $display("FAIL w8[%0d]: got lat=%0d co=%b sum=%h ov=%b, want lat=8 co=%b sum=%h ov=%b",
                 v, lat, carry_out8, sum8, overflow8, exp[8], exp[7:0], exp_ov);
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_exhaustive();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
